security_zone_ctrl: RTL and testbench
=====================================

SECURITY_ZONE_CTRL -- requirements
Module: security_zone_ctrl

Interface
REQ-001 Parameter NUM_ZONES, default 4: number of sensor zones, legal range 1..16.
REQ-002 Parameter EXIT_CYCLES, default 16: exit-delay length in clocks, at least 1.
REQ-003 Parameter ENTRY_CYCLES, default 16: entry-delay length in clocks, at least 1.
REQ-004 Parameter SIREN_CYCLES, default 64: siren-on duration in clocks, at least 1.
REQ-005 clk  in  1  clock; one clock domain; every flop SHALL be rising-edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 arm  in  1  arm request; level sampled each clock.
REQ-008 disarm  in  1  disarm request; level sampled each clock.
REQ-009 sensor  in  NUM_ZONES  per-zone trip inputs, active-high, already synchronous to clk.
REQ-010 zone_en  in  NUM_ZONES  per-zone enable; a disabled zone SHALL be ignored.
REQ-011 zone_instant  in  NUM_ZONES  per-zone instant flag; a trip on this zone bypasses the entry delay.
REQ-012 state  out  3  current state encoding, registered.
REQ-013 armed  out  1  high in EXIT_DELAY, ARMED, ENTRY_DELAY and ALARM.
REQ-014 siren  out  1  registered siren drive.
REQ-015 trip_zones  out  NUM_ZONES  sticky record of the zones that caused entry delay or alarm.
REQ-016 timer  out  clog2(max(EXIT_CYCLES,ENTRY_CYCLES,SIREN_CYCLES)+1) bits  current countdown value.

Function
REQ-017 States and encodings SHALL be: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4.
REQ-018 Any other encoding SHALL return to DISARMED on the next clock.
REQ-019 Define trip = sensor & zone_en, evaluated per zone.
REQ-020 DISARMED: arm=1 and disarm=0 -> EXIT_DELAY; timer loads EXIT_CYCLES-1; trip_zones clears to 0.
REQ-021 EXIT_DELAY: trips SHALL be ignored.
REQ-022 EXIT_DELAY: when timer==0 -> ARMED, so EXIT_DELAY lasts exactly EXIT_CYCLES clocks; otherwise timer decrements by 1.
REQ-023 ARMED: a trip on any instant zone -> ALARM.
REQ-024 ARMED: otherwise a trip on any non-instant zone -> ENTRY_DELAY, with timer loaded to ENTRY_CYCLES-1.
REQ-025 ARMED: in either case trip_zones |= trip.
REQ-026 ENTRY_DELAY: timer decrements by 1 each clock and trip_zones |= trip.
REQ-027 ENTRY_DELAY: a trip on an instant zone -> ALARM immediately.
REQ-028 ENTRY_DELAY: timer==0 -> ALARM, so ENTRY_DELAY lasts exactly ENTRY_CYCLES clocks.
REQ-029 On entry to ALARM, timer SHALL load SIREN_CYCLES-1 and siren SHALL be 1 from the next clock.
REQ-030 ALARM: timer decrements to 0, then siren drops to 0 and state remains ALARM (latched alarm, siren silenced).
REQ-031 ALARM: further trips SHALL OR into trip_zones; the siren SHALL NOT retrigger.
REQ-032 disarm=1 in any state other than DISARMED -> DISARMED on the next clock, with siren=0 and timer=0; trip_zones SHALL be retained for readout.
REQ-033 disarm SHALL take priority over arm, trips and timer expiry in the same cycle.
REQ-034 arm SHALL be ignored in every state other than DISARMED.
REQ-035 A trip coincident with timer==0 in ENTRY_DELAY SHALL still OR into trip_zones.
REQ-036 When timer is not in use it SHALL hold 0; it SHALL never underflow.
REQ-037 siren SHALL be 0 in every state other than ALARM.
REQ-038 Every output SHALL be driven from flops, with no combinational path from input to output.

Reset
REQ-039 rst=1 SHALL force, on the next clock: state=DISARMED, armed=0, siren=0, trip_zones=0, timer=0.
REQ-040 rst SHALL override all inputs.
REQ-041 rst mid-delay or mid-alarm SHALL abandon the operation with no residual count.

Structure
REQ-042 A shared package security_pkg SHALL hold the state encoding constants and the 3-bit state type, for reuse by the host and the bench.
REQ-043 One sub-module, sec_countdown, SHALL implement the loadable down-counter: load, load value, enable and zero flag, parametrised width.
REQ-044 The zone logic SHALL be plain vector operations, with no per-zone instances.

Verification
REQ-045 Exit delay: EXIT_CYCLES=4; pulse arm; hold sensor[0]=1 throughout with zone_en=4'hF -> EXIT_DELAY for 4 clocks, then ARMED; trip_zones==0 on entry to ARMED, and state is ENTRY_DELAY one clock after ARMED.
REQ-046 Entry expiry: in ARMED, pulse sensor[1] (non-instant) -> ENTRY_DELAY for ENTRY_CYCLES=4 clocks, then ALARM; siren=1 for exactly SIREN_CYCLES=8 clocks, then 0 while state stays 4; trip_zones=4'b0010.
REQ-047 Instant zone: zone_instant=4'b1000; in ENTRY_DELAY assert sensor[3] with timer=2 -> ALARM on the next clock; trip_zones=4'b1010.
REQ-048 Priority: in ENTRY_DELAY with timer=0, assert disarm and sensor[3] together -> DISARMED, siren=0, trip_zones includes bit 3.
REQ-049 Masking and arm: zone_en=4'b0111 with sensor[3]=1 in ARMED -> stays ARMED; arm pulsed while ARMED -> no change.
REQ-050 Reset: assert rst in ALARM with siren=1 -> next clock state=0, siren=0, trip_zones=0, timer=0.

Source files
------------

// File: rtl/security_pkg.sv
// Shared definitions for the security zone controller: state encoding and
// sizing helpers used by the RTL and the bench.
package security_pkg;

    typedef enum logic [2:0] {
        StDisarmed   = 3'd0,
        StExitDelay  = 3'd1,
        StArmed      = 3'd2,
        StEntryDelay = 3'd3,
        StAlarm      = 3'd4
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic is_armed_state(input state_e s);
        return (s == StExitDelay) || (s == StArmed) || (s == StEntryDelay) || (s == StAlarm);
    endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable down-counter that saturates at zero; load wins over enable.
module sec_countdown #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/security_zone_ctrl.sv
// Alarm-panel controller: exit/entry delays, instant zones, latched alarm with
// timed siren, and a sticky record of the zones that tripped.
module security_zone_ctrl
    import security_pkg::*;
#(
    parameter int unsigned NUM_ZONES    = 4,
    parameter int unsigned EXIT_CYCLES  = 16,
    parameter int unsigned ENTRY_CYCLES = 16,
    parameter int unsigned SIREN_CYCLES = 64,
    localparam int unsigned TIMER_W =
        $clog2(max3(EXIT_CYCLES, ENTRY_CYCLES, SIREN_CYCLES) + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arm,
    input  logic                 disarm,
    input  logic [NUM_ZONES-1:0] sensor,
    input  logic [NUM_ZONES-1:0] zone_en,
    input  logic [NUM_ZONES-1:0] zone_instant,
    output logic [2:0]           state,
    output logic                 armed,
    output logic                 siren,
    output logic [NUM_ZONES-1:0] trip_zones,
    output logic [TIMER_W-1:0]   timer
);

    localparam logic [TIMER_W-1:0] EXIT_LOAD  = TIMER_W'(EXIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ENTRY_LOAD = TIMER_W'(ENTRY_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SIREN_LOAD = TIMER_W'(SIREN_CYCLES - 1);

    state_e               state_q, state_d;
    logic                 armed_q, armed_d;
    logic                 siren_q, siren_d;
    logic [NUM_ZONES-1:0] trip_q, trip_d;

    logic                 cnt_load, cnt_en, cnt_zero;
    logic [TIMER_W-1:0]   cnt_val, cnt_value;

    logic [NUM_ZONES-1:0] trip;
    logic                 trip_any, trip_inst;

    assign trip      = sensor & zone_en;
    assign trip_any  = |trip;
    assign trip_inst = |(trip & zone_instant);

    sec_countdown #(
        .WIDTH (TIMER_W)
    ) u_countdown (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .en       (cnt_en),
        .count    (cnt_value),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        siren_d  = siren_q;
        trip_d   = trip_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_en   = 1'b0;

        case (state_q)
            StDisarmed: begin
                siren_d = 1'b0;
                if (arm && !disarm) begin
                    state_d  = StExitDelay;
                    cnt_load = 1'b1;
                    cnt_val  = EXIT_LOAD;
                    trip_d   = '0;
                end
            end
            StExitDelay: begin
                if (cnt_zero) begin
                    state_d = StArmed;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StArmed: begin
                trip_d = trip_q | trip;
                if (trip_inst) begin
                    state_d  = StAlarm;
                    siren_d  = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = SIREN_LOAD;
                end else if (trip_any) begin
                    state_d  = StEntryDelay;
                    cnt_load = 1'b1;
                    cnt_val  = ENTRY_LOAD;
                end
            end
            StEntryDelay: begin
                trip_d = trip_q | trip;
                if (trip_inst || cnt_zero) begin
                    state_d  = StAlarm;
                    siren_d  = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = SIREN_LOAD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StAlarm: begin
                // Siren runs once per alarm; later trips are only recorded.
                trip_d = trip_q | trip;
                if (cnt_zero) begin
                    siren_d = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                state_d  = StDisarmed;
                siren_d  = 1'b0;
                cnt_load = 1'b1;
                cnt_val  = '0;
            end
        endcase

        // Disarm overrides everything except the trip record, kept for readout.
        if (disarm && (state_q != StDisarmed)) begin
            state_d  = StDisarmed;
            siren_d  = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = '0;
            cnt_en   = 1'b0;
        end

        armed_d = is_armed_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StDisarmed;
            armed_q <= 1'b0;
            siren_q <= 1'b0;
            trip_q  <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
            siren_q <= siren_d;
            trip_q  <= trip_d;
        end
    end

    assign state      = state_q;
    assign armed      = armed_q;
    assign siren      = siren_q;
    assign trip_zones = trip_q;
    assign timer      = cnt_value;

endmodule

// File: tb/tb_security_zone_ctrl.sv
// Directed bench for security_zone_ctrl: cycle-by-cycle vector table plus
// hand-written siren-duration, priority and reset sequences.
module tb_security_zone_ctrl;
    import security_pkg::*;

    localparam int unsigned NZ = 4;
    localparam int unsigned TW = 4;

    logic          clk;
    logic          rst, arm, disarm;
    logic [NZ-1:0] sensor, zone_en, zone_instant;
    logic [2:0]    state;
    logic          armed, siren;
    logic [NZ-1:0] trip_zones;
    logic [TW-1:0] timer;

    security_zone_ctrl #(
        .NUM_ZONES    (NZ),
        .EXIT_CYCLES  (4),
        .ENTRY_CYCLES (4),
        .SIREN_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .arm          (arm),
        .disarm       (disarm),
        .sensor       (sensor),
        .zone_en      (zone_en),
        .zone_instant (zone_instant),
        .state        (state),
        .armed        (armed),
        .siren        (siren),
        .trip_zones   (trip_zones),
        .timer        (timer)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          arm;
        logic          dis;
        logic [NZ-1:0] sen;
        logic [NZ-1:0] zen;
        logic [2:0]    st;
        logic          armd;
        logic          sir;
        logic [NZ-1:0] trp;
        logic [TW-1:0] tmr;
    } vec_t;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    function automatic void add(input logic r, input logic a, input logic d,
                                input logic [NZ-1:0] s, input logic [NZ-1:0] ze,
                                input logic [2:0] st, input logic am, input logic sr,
                                input logic [NZ-1:0] tp, input logic [TW-1:0] tm);
        vec_t v;
        v.rst = r; v.arm = a; v.dis = d; v.sen = s; v.zen = ze;
        v.st = st; v.armd = am; v.sir = sr; v.trp = tp; v.tmr = tm;
        vecs.push_back(v);
    endfunction

    task automatic step(input logic r, input logic a, input logic d,
                        input logic [NZ-1:0] s, input logic [NZ-1:0] ze);
        rst = r; arm = a; disarm = d; sensor = s; zone_en = ze;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {3'b0, state, armed, siren, trip_zones, timer};
    endfunction

    function automatic logic [15:0] pack(input logic [2:0] st, input logic am, input logic sr,
                                         input logic [NZ-1:0] tp, input logic [TW-1:0] tm);
        return {3'b0, st, am, sr, tp, tm};
    endfunction

    task automatic to_armed(input string tag);
        step(0, 1, 0, 4'h0, 4'hF);
        check({tag, "_exit_entry"}, 16'(state), 16'(StExitDelay));
        for (int i = 0; i < 10 && state != 3'(StArmed); i++) step(0, 0, 0, 4'h0, 4'hF);
        check({tag, "_armed"}, 16'(state), 16'(StArmed));
    endtask

    initial begin
        int hi;
        zone_instant = 4'b1000;
        rst = 1'b1; arm = 1'b0; disarm = 1'b0; sensor = '0; zone_en = 4'hF;

        //   rst arm dis sen   zen    state         arm sir trip  tmr
        add(1, 0, 0, 4'h0, 4'hF, StDisarmed,   0, 0, 4'h0, 4'd0);
        add(0, 0, 0, 4'h0, 4'hF, StDisarmed,   0, 0, 4'h0, 4'd0);
        add(0, 1, 1, 4'h0, 4'hF, StDisarmed,   0, 0, 4'h0, 4'd0);
        add(0, 1, 0, 4'h1, 4'hF, StExitDelay,  1, 0, 4'h0, 4'd3);
        add(0, 0, 0, 4'h1, 4'hF, StExitDelay,  1, 0, 4'h0, 4'd2);
        add(0, 1, 0, 4'h1, 4'hF, StExitDelay,  1, 0, 4'h0, 4'd1);
        add(0, 0, 0, 4'h1, 4'hF, StExitDelay,  1, 0, 4'h0, 4'd0);
        add(0, 0, 0, 4'h1, 4'hF, StArmed,      1, 0, 4'h0, 4'd0);
        add(0, 0, 0, 4'h1, 4'hF, StEntryDelay, 1, 0, 4'h1, 4'd3);
        add(0, 0, 1, 4'h0, 4'hF, StDisarmed,   0, 0, 4'h1, 4'd0);
        add(0, 1, 0, 4'h0, 4'hF, StExitDelay,  1, 0, 4'h0, 4'd3);
        add(0, 0, 0, 4'h0, 4'hF, StExitDelay,  1, 0, 4'h0, 4'd2);
        add(0, 0, 0, 4'h0, 4'hF, StExitDelay,  1, 0, 4'h0, 4'd1);
        add(0, 0, 0, 4'h0, 4'hF, StExitDelay,  1, 0, 4'h0, 4'd0);
        add(0, 0, 0, 4'h0, 4'hF, StArmed,      1, 0, 4'h0, 4'd0);
        add(0, 0, 0, 4'h8, 4'h7, StArmed,      1, 0, 4'h0, 4'd0);
        add(0, 1, 0, 4'h0, 4'hF, StArmed,      1, 0, 4'h0, 4'd0);
        add(0, 0, 0, 4'h2, 4'hF, StEntryDelay, 1, 0, 4'h2, 4'd3);
        add(0, 0, 0, 4'h0, 4'hF, StEntryDelay, 1, 0, 4'h2, 4'd2);
        add(0, 0, 0, 4'h8, 4'hF, StAlarm,      1, 1, 4'hA, 4'd7);
        add(0, 0, 0, 4'h0, 4'hF, StAlarm,      1, 1, 4'hA, 4'd6);
        add(0, 1, 0, 4'h0, 4'hF, StAlarm,      1, 1, 4'hA, 4'd5);
        add(0, 0, 0, 4'h2, 4'hF, StAlarm,      1, 1, 4'hA, 4'd4);
        add(0, 0, 1, 4'h0, 4'hF, StDisarmed,   0, 0, 4'hA, 4'd0);
        add(0, 1, 0, 4'h0, 4'hF, StExitDelay,  1, 0, 4'h0, 4'd3);
        add(0, 0, 0, 4'h0, 4'hF, StExitDelay,  1, 0, 4'h0, 4'd2);
        add(0, 0, 0, 4'h0, 4'hF, StExitDelay,  1, 0, 4'h0, 4'd1);
        add(0, 0, 0, 4'h0, 4'hF, StExitDelay,  1, 0, 4'h0, 4'd0);
        add(0, 0, 0, 4'h0, 4'hF, StArmed,      1, 0, 4'h0, 4'd0);
        add(0, 0, 0, 4'h2, 4'hF, StEntryDelay, 1, 0, 4'h2, 4'd3);
        add(0, 0, 0, 4'h0, 4'hF, StEntryDelay, 1, 0, 4'h2, 4'd2);
        add(0, 0, 0, 4'h0, 4'hF, StEntryDelay, 1, 0, 4'h2, 4'd1);
        add(0, 0, 0, 4'h0, 4'hF, StEntryDelay, 1, 0, 4'h2, 4'd0);
        add(0, 0, 0, 4'h0, 4'hF, StAlarm,      1, 1, 4'h2, 4'd7);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].arm, vecs[i].dis, vecs[i].sen, vecs[i].zen);
            check($sformatf("vec%0d", i), outs(),
                  pack(vecs[i].st, vecs[i].armd, vecs[i].sir, vecs[i].trp, vecs[i].tmr));
        end

        // Siren duration: already high for one sampled cycle after the last vector.
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 4'h0, 4'hF);
            if (siren) hi++;
            else break;
        end
        check("siren_len", 16'(hi), 16'd8);
        check("siren_off", outs(), pack(StAlarm, 1, 0, 4'h2, 4'd0));
        step(0, 0, 0, 4'h1, 4'hF);
        step(0, 0, 0, 4'h0, 4'hF);
        check("alarm_latched", outs(), pack(StAlarm, 1, 0, 4'h3, 4'd0));

        // Disarm vs instant trip at entry-timer expiry.
        step(0, 0, 1, 4'h0, 4'hF);
        check("disarm_alarm", outs(), pack(StDisarmed, 0, 0, 4'h3, 4'd0));
        to_armed("prio");
        step(0, 0, 0, 4'h2, 4'hF);
        step(0, 0, 0, 4'h0, 4'hF);
        step(0, 0, 0, 4'h0, 4'hF);
        step(0, 0, 0, 4'h0, 4'hF);
        check("prio_t0", outs(), pack(StEntryDelay, 1, 0, 4'h2, 4'd0));
        step(0, 1, 1, 4'h8, 4'hF);
        check("prio_disarm", outs(), pack(StDisarmed, 0, 0, 4'hA, 4'd0));

        // Reset while the siren is sounding.
        to_armed("rst");
        step(0, 0, 0, 4'h8, 4'hF);
        check("rst_alarm", outs(), pack(StAlarm, 1, 1, 4'h8, 4'd7));
        step(1, 1, 0, 4'h8, 4'hF);
        check("rst_clear", outs(), pack(StDisarmed, 0, 0, 4'h0, 4'd0));
        step(0, 0, 0, 4'h0, 4'hF);
        check("rst_idle", outs(), pack(StDisarmed, 0, 0, 4'h0, 4'd0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
